uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 139 +++++++++++++
 tb/tb_uart_tx_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// Latency: start bit drives TxOut one cycle after Send is accepted; each bit lasts BAUD_DIV cycles.
// Backpressure: Send is taken only in IDLE or in the Done cycle; it is ignored at all other times.
// Build option: define UART_TX_PARITY_EN to insert the parity bit (11-bit frame); otherwise 10-bit frame.
module uart_tx_core #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       Send,
  input  logic [7:0] DataIn,
  input  logic       ParityType,
  output logic       TxOut,
  output logic       Busy,
  output logic       Done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(BAUD_DIV - 2);

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  // Bit 8 holds the precomputed parity bit; after eight shifts it sits in bit 0.
  logic [8:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic bit_end;
  logic accept;

  assign bit_end = (baud_q == BAUD_LAST);
  // Done is high during the final stop-bit cycle, so a Send seen then chains with no idle gap.
  assign accept  = Send && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  // Next-state logic: bit timing, FSM sequencing and frame capture.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[8:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          baud_d  = 16'd0;
        end
      end
      S_STOP: begin
        done_d = (baud_q == BAUD_PRE);
        if (bit_end) begin
          state_d = S_IDLE;
          baud_d  = 16'd0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d = S_START;
      baud_d  = 16'd0;
      bit_d   = 3'd0;
      shift_d = {(^DataIn) ^ ParityType, DataIn};
      busy_d  = 1'b1;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State and registered outputs; synchronous active-low reset aborts any frame.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 9'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TxOut = tx_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core at BAUD_DIV=4: table of single frames plus back-to-back and reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Frame length follows UART_TX_PARITY_EN (11 bits with parity, 10 without).
module tb_uart_tx_core;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LEN = NBITS * BD;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       Send;
  logic [7:0] DataIn;
  logic       ParityType;
  logic       TxOut;
  logic       Busy;
  logic       Done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       ptype;
    logic       exp_par;
  } vec_t;

  vec_t vecs [8];

  uart_tx_core #(.BAUD_DIV(BD)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .Send       (Send),
    .DataIn     (DataIn),
    .ParityType (ParityType),
    .TxOut      (TxOut),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Expected wire bits, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par);
    logic [10:0] f;
    f       = 11'h7FF;
    f[0]    = 1'b0;
    f[8:1]  = d;
`ifdef UART_TX_PARITY_EN
    f[9]    = par;
    f[10]   = 1'b1;
`else
    f[9]    = 1'b1;
`endif
    return f;
  endfunction

  // Checks cycles 1..LEN after the acceptance edge; the caller has set the inputs for cycle 0.
  task automatic check_frame(input logic [10:0] f, input string nm, input logic poke,
                             input logic end_send, input logic [7:0] end_d, input logic end_pt);
    for (int c = 1; c <= LEN; c++) begin
      @(negedge Clock);
      chk({nm, " tx"},   {31'd0, TxOut}, {31'd0, f[(c - 1) / BD]});
      chk({nm, " busy"}, {31'd0, Busy},  32'd1);
      chk({nm, " done"}, {31'd0, Done},  {31'd0, (c == LEN)});
      if (poke) begin
        if (c == 1) begin
          Send       = 1'b0;
          DataIn     = ~DataIn;
          ParityType = ~ParityType;
        end
        if (c == 10) Send = 1'b1;
        if (c == 11) Send = 1'b0;
      end
      if (c == LEN) begin
        Send       = end_send;
        DataIn     = end_d;
        ParityType = end_pt;
      end
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge Clock);
    chk({nm, " idle tx"},   {31'd0, TxOut}, 32'd1);
    chk({nm, " idle busy"}, {31'd0, Busy},  32'd0);
    chk({nm, " idle done"}, {31'd0, Done},  32'd0);
  endtask

  initial begin
    logic [10:0] f;

    vecs[0] = '{data: 8'hA5, ptype: 1'b0, exp_par: 1'b0};
    vecs[1] = '{data: 8'h01, ptype: 1'b1, exp_par: 1'b0};
    vecs[2] = '{data: 8'h01, ptype: 1'b0, exp_par: 1'b1};
    vecs[3] = '{data: 8'h80, ptype: 1'b0, exp_par: 1'b1};
    vecs[4] = '{data: 8'hFF, ptype: 1'b1, exp_par: 1'b1};
    vecs[5] = '{data: 8'h3C, ptype: 1'b0, exp_par: 1'b0};
    vecs[6] = '{data: 8'hC3, ptype: 1'b1, exp_par: 1'b1};
    vecs[7] = '{data: 8'h00, ptype: 1'b1, exp_par: 1'b1};

    ResetN     = 1'b0;
    Send       = 1'b1;
    DataIn     = 8'h55;
    ParityType = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset tx",   {31'd0, TxOut}, 32'd1);
    chk("reset busy", {31'd0, Busy},  32'd0);
    chk("reset done", {31'd0, Done},  32'd0);
    Send   = 1'b0;
    ResetN = 1'b1;
    check_idle("post reset");

    // Single frames from the table, with input changes and a stray Send mid-frame.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      Send       = 1'b1;
      DataIn     = vecs[i].data;
      ParityType = vecs[i].ptype;
      f = frame_bits(vecs[i].data, vecs[i].exp_par);
      check_frame(f, $sformatf("vec%0d", i), 1'b1, 1'b0, 8'h00, 1'b0);
      check_idle($sformatf("vec%0d", i));
    end

    // Back-to-back: Send held high, new byte presented in the Done cycle.
    @(negedge Clock);
    Send       = 1'b1;
    DataIn     = 8'h3C;
    ParityType = 1'b0;
    check_frame(frame_bits(8'h3C, 1'b0), "b2b first", 1'b0, 1'b1, 8'hC3, 1'b1);
    check_frame(frame_bits(8'hC3, 1'b1), "b2b second", 1'b0, 1'b0, 8'h00, 1'b0);
    check_idle("b2b");

    // Reset pulse during data bit 3 of 8'hFF.
    @(negedge Clock);
    Send       = 1'b1;
    DataIn     = 8'hFF;
    ParityType = 1'b0;
    f = frame_bits(8'hFF, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge Clock);
      chk("abort tx", {31'd0, TxOut}, {31'd0, f[(c - 1) / BD]});
      if (c == 1) Send = 1'b0;
    end
    ResetN = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
    chk("abort tx after reset",   {31'd0, TxOut}, 32'd1);
    chk("abort busy after reset", {31'd0, Busy},  32'd0);
    chk("abort done after reset", {31'd0, Done},  32'd0);
    for (int c = 0; c < LEN; c++) begin
      @(negedge Clock);
      chk("abort no done", {31'd0, Done},  32'd0);
      chk("abort line",    {31'd0, TxOut}, 32'd1);
    end
    @(negedge Clock);
    Send       = 1'b1;
    DataIn     = 8'hFF;
    ParityType = 1'b1;
    check_frame(frame_bits(8'hFF, 1'b1), "after abort", 1'b1, 1'b0, 8'h00, 1'b0);
    check_idle("after abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
